// File: rtl/blend_pkg.sv
// rtl/blend_pkg.sv - shared types and constants for the blend pipeline
package blend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    FADE_OUT = 2'd2
  } fade_state_t;

  localparam logic [1:0] MODE_MANUAL   = 2'b00;
  localparam logic [1:0] MODE_FADE_IN  = 2'b01;
  localparam logic [1:0] MODE_FADE_OUT = 2'b10;

  // RGB565 layout: {red[15:11], green[10:5], blue[4:0]}
  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_B_MSB = 4;
  localparam int RGB565_B_LSB = 0;

endpackage

// File: rtl/blend_pipeline_fade_controller.sv
// rtl/blend_pipeline_fade_controller.sv - per-frame alpha register with fade-in/out ramp FSM
module fade_controller
  import blend_pkg::*;
#(
  parameter int AW          = 3,
  parameter int FADE_FRAMES = 8
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          frame_start_in,
  input  logic [1:0]    mode_in,
  input  logic [AW-1:0] alpha_manual_in,
  input  logic          go_in,
  output logic [AW-1:0] alpha_out,
  output logic          busy_out,
  output logic          done_out
);

  localparam logic [AW-1:0] FULL = AW'(2 ** (AW - 1));
  localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FADE_FRAMES - 1);

  fade_state_t      state;
  logic [CNT_W-1:0] frame_cnt;
  logic [AW-1:0]    manual_clamped;
  logic             is_manual;

  assign manual_clamped = (alpha_manual_in > FULL) ? FULL : alpha_manual_in;
  assign is_manual      = (mode_in != MODE_FADE_IN) && (mode_in != MODE_FADE_OUT);
  assign busy_out       = (state != IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      alpha_out <= '0;
      frame_cnt <= '0;
      done_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          // a go pulse takes priority over a coincident frame start
          if (go_in && mode_in == MODE_FADE_IN) begin
            alpha_out <= '0;
            frame_cnt <= '0;
            state     <= FADE_IN;
          end else if (go_in && mode_in == MODE_FADE_OUT) begin
            alpha_out <= FULL;
            frame_cnt <= '0;
            state     <= FADE_OUT;
          end else if (frame_start_in && is_manual) begin
            alpha_out <= manual_clamped;
          end
        end
        FADE_IN: begin
          if (frame_start_in) begin
            if (frame_cnt == LAST_CNT) begin
              frame_cnt <= '0;
              alpha_out <= alpha_out + 1'b1;
              if (alpha_out == FULL - 1'b1) begin
                state    <= IDLE;
                done_out <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        FADE_OUT: begin
          if (frame_start_in) begin
            if (frame_cnt == LAST_CNT) begin
              frame_cnt <= '0;
              alpha_out <= alpha_out - 1'b1;
              if (alpha_out == AW'(1)) begin
                state    <= IDLE;
                done_out <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/blend_pipeline.sv
// rtl/blend_pipeline.sv - three-stage recolour and alpha-blend compositor on a valid/ready stream
module blend_pipeline
  import blend_pkg::*;
#(
  parameter int CW           = 4,
  parameter int AW           = 3,
  parameter int GREEN_THRESH = 48,
  parameter int FADE_FRAMES  = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [3*CW-1:0] truth_pixel_in,
  input  logic [15:0]     user_pixel_in,
  input  logic            valid_in,
  output logic            ready_out,
  output logic [3*CW-1:0] pixel_out,
  output logic            valid_out,
  input  logic            ready_in,
  input  logic            frame_start_in,
  input  logic [1:0]      alpha_mode_in,
  input  logic [AW-1:0]   alpha_manual_in,
  input  logic            fade_go_in,
  output logic            fade_busy_out,
  output logic            fade_done_out,
  output logic [AW-1:0]   alpha_out
);

  localparam int PW = 3 * CW;
  localparam int MW = CW + AW;
  localparam int SW = MW + 1;
  localparam logic [AW-1:0] FULL   = AW'(2 ** (AW - 1));
  localparam logic [CW-1:0] CH_MAX = '1;

  logic          adv;
  logic [AW-1:0] alpha_cur;
  logic          user_on;
  logic [PW-1:0] user_rc;
  logic          unused_rb;

  logic          s1_valid;
  logic [PW-1:0] s1_truth;
  logic [PW-1:0] s1_user;
  logic [AW-1:0] s1_alpha;
  logic [AW-1:0] alpha_n;

  logic [3*MW-1:0] pt_all;
  logic [3*MW-1:0] pu_all;
  logic [3*MW-1:0] s2_pt;
  logic [3*MW-1:0] s2_pu;
  logic            s2_valid;
  logic            s2_bypass;
  logic [PW-1:0]   s2_raw;
  logic [PW-1:0]   blended;

  // one global enable: a stalled output freezes every stage
  assign adv       = !valid_out || ready_in;
  assign ready_out = adv;
  assign alpha_out = alpha_cur;

  fade_controller #(
    .AW          (AW),
    .FADE_FRAMES (FADE_FRAMES)
  ) u_fade (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .frame_start_in  (frame_start_in),
    .mode_in         (alpha_mode_in),
    .alpha_manual_in (alpha_manual_in),
    .go_in           (fade_go_in),
    .alpha_out       (alpha_cur),
    .busy_out        (fade_busy_out),
    .done_out        (fade_done_out)
  );

  assign user_on   = int'(user_pixel_in[RGB565_G_MSB:RGB565_G_LSB]) > GREEN_THRESH;
  assign user_rc   = user_on ? {{CW{1'b0}}, {CW{1'b1}}, {CW{1'b0}}} : '0;
  assign unused_rb = ^{user_pixel_in[RGB565_R_MSB:RGB565_R_LSB],
                       user_pixel_in[RGB565_B_MSB:RGB565_B_LSB]};

  assign alpha_n = FULL - s1_alpha;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [SW-1:0] sum;
    logic [SW-1:0] scaled;
    assign pt_all[c*MW +: MW] = MW'(s1_truth[c*CW +: CW]) * MW'(s1_alpha);
    assign pu_all[c*MW +: MW] = MW'(s1_user[c*CW +: CW]) * MW'(alpha_n);
    assign sum    = {1'b0, s2_pt[c*MW +: MW]} + {1'b0, s2_pu[c*MW +: MW]};
    assign scaled = sum >> (AW - 1);
    assign blended[c*CW +: CW] = (scaled > SW'(CH_MAX)) ? CH_MAX : scaled[CW-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid  <= 1'b0;
      s1_truth  <= '0;
      s1_user   <= '0;
      s1_alpha  <= '0;
      s2_valid  <= 1'b0;
      s2_pt     <= '0;
      s2_pu     <= '0;
      s2_bypass <= 1'b0;
      s2_raw    <= '0;
      valid_out <= 1'b0;
      pixel_out <= '0;
    end else if (adv) begin
      s1_valid  <= valid_in;
      s1_truth  <= truth_pixel_in;
      s1_user   <= user_rc;
      s1_alpha  <= alpha_cur;
      s2_valid  <= s1_valid;
      s2_pt     <= pt_all;
      s2_pu     <= pu_all;
      // an empty layer passes the other through unblended
      s2_bypass <= (s1_truth == '0) || (s1_user == '0);
      s2_raw    <= s1_truth | s1_user;
      valid_out <= s2_valid;
      pixel_out <= s2_bypass ? s2_raw : blended;
    end
  end

endmodule
